mcb_command_dispatcher: RTL and testbench

//  Sits in FPGA_MainControl_Block behind instr_data_buffer. Queues each decoded command
//  (instruction + 64-bit data + target class) and dispatches it, one at a time, to the

---
 rtl/mcb_command_dispatcher_pkg.sv | 51 +++++
 rtl/mcb_cmd_fifo.sv | 58 +++++
 rtl/mcb_command_dispatcher.sv | 180 ++++++++++++++++++
 tb/tb_mcb_command_dispatcher.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mcb_command_dispatcher_pkg.sv
// Shared definitions for the MCB command dispatcher: target codes, FSM
// encodings, the queued command layout and small decode helpers.
package mcb_command_dispatcher_pkg;

  typedef enum logic [1:0] {
    TGT_NONE     = 2'd0,
    TGT_CAMWRITE = 2'd1,
    TGT_READ     = 2'd2,
    TGT_MEM      = 2'd3
  } target_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  localparam int CMD_ENTRY_W = 74;

  typedef struct packed {
    target_e     target;
    logic [7:0]  instruction;
    logic [63:0] data;
  } cmd_entry_t;

  // valid vector is {camwrite, read, mem}; anything but exactly one bit -> no target
  function automatic target_e decode_valid(input logic [2:0] v);
    case (v)
      3'b100:  return TGT_CAMWRITE;
      3'b010:  return TGT_READ;
      3'b001:  return TGT_MEM;
      default: return TGT_NONE;
    endcase
  endfunction

  // true when two or more of the three valid pulses coincide
  function automatic logic multiple_set(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // request vector {camwrite, read, mem} for a target code
  function automatic logic [2:0] target_req(input target_e t);
    case (t)
      TGT_CAMWRITE: return 3'b100;
      TGT_READ:     return 3'b010;
      TGT_MEM:      return 3'b001;
      default:      return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/mcb_cmd_fifo.sv
// Synchronous command FIFO. Head entry is read straight from the storage
// registers so the dispatcher can capture it on the same edge it pops.
// A push while full is accepted only when a pop happens on the same edge.
module mcb_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 74
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == {(AW+1){1'b0}});
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written so no reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/mcb_command_dispatcher.sv
// MCB command dispatcher: queues decoded commands and hands them one at a
// time to the camera-write, read or memory interface over a req/done
// handshake, with a per-command timeout and sticky error flags.
module mcb_command_dispatcher #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_W      = 24,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        sysClk,
  input  logic        sysRst,
  input  logic [7:0]  instruction,
  input  logic [63:0] data,
  input  logic        valid_buffer_for_camwrite,
  input  logic        valid_buffer_for_read,
  input  logic        valid_buffer_for_mem,
  input  logic        camwrite_done,
  input  logic        read_done,
  input  logic        mem_done,
  input  logic        clear_flags,
  output logic        camwrite_req,
  output logic        read_req,
  output logic        mem_req,
  output logic [7:0]  cmd_instruction,
  output logic [63:0] cmd_data,
  output logic        busy,
  output logic        queue_full,
  output logic        overflow_flag,
  output logic        multi_valid_flag,
  output logic        timeout_flag,
  output logic [1:0]  timeout_target
);

  import mcb_command_dispatcher_pkg::*;

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] CNT_ONE      = TIMEOUT_W'(1);

  logic [2:0]                 valid_vec;
  logic [2:0]                 done_vec;
  logic [2:0]                 req_vec;
  target_e                    valid_tgt;
  target_e                    active_tgt;
  logic                       push;
  logic                       pop;
  logic                       multi_valid;
  logic                       overflow_evt;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       done_hit;
  logic                       leave_issue;
  logic                       timeout_evt;
  cmd_entry_t                 wr_entry;
  cmd_entry_t                 head_entry;
  logic [CMD_ENTRY_W-1:0]     head_bits;
  state_e                     state;
  state_e                     state_next;
  logic [TIMEOUT_W-1:0]       cnt;

  assign valid_vec    = {valid_buffer_for_camwrite, valid_buffer_for_read, valid_buffer_for_mem};
  assign done_vec     = {camwrite_done, read_done, mem_done};
  assign valid_tgt    = decode_valid(valid_vec);
  assign multi_valid  = multiple_set(valid_vec);
  assign push         = (valid_tgt != TGT_NONE);
  assign overflow_evt = push && fifo_full && !pop;
  assign wr_entry     = '{target: valid_tgt, instruction: instruction, data: data};
  assign head_entry   = head_bits;
  // only the active target's done can match because req_vec is one-hot
  assign done_hit     = |(done_vec & req_vec);

  assign camwrite_req = req_vec[2];
  assign read_req     = req_vec[1];
  assign mem_req      = req_vec[0];
  assign queue_full   = fifo_full;
  assign busy         = (state != ST_IDLE) || !fifo_empty;

  mcb_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_ENTRY_W)
  ) u_fifo (
    .clk     (sysClk),
    .rst     (sysRst),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .head    (head_bits),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Dispatcher state register
  always_ff @(posedge sysClk) begin
    if (sysRst) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state and pop/abort decisions; done beats timeout on the same cycle
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    leave_issue = 1'b0;
    timeout_evt = 1'b0;
    case (state)
      ST_IDLE, ST_RECOVER: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ST_ISSUE;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (done_hit) begin
          leave_issue = 1'b1;
          state_next  = ST_RECOVER;
        end else if (cnt == TIMEOUT_LAST) begin
          leave_issue = 1'b1;
          timeout_evt = 1'b1;
          state_next  = ST_RECOVER;
        end else begin
          state_next  = ST_ISSUE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Active command capture, request levels and issue-cycle counter
  always_ff @(posedge sysClk) begin
    if (sysRst) begin
      req_vec         <= 3'b000;
      cmd_instruction <= 8'h00;
      cmd_data        <= 64'h0;
      active_tgt      <= TGT_NONE;
      cnt             <= {TIMEOUT_W{1'b0}};
    end else if (pop) begin
      req_vec         <= target_req(head_entry.target);
      cmd_instruction <= head_entry.instruction;
      cmd_data        <= head_entry.data;
      active_tgt      <= head_entry.target;
      cnt             <= {TIMEOUT_W{1'b0}};
    end else if (leave_issue) begin
      req_vec         <= 3'b000;
      cnt             <= {TIMEOUT_W{1'b0}};
    end else if (state == ST_ISSUE) begin
      cnt             <= cnt + CNT_ONE;
    end else begin
      cnt             <= cnt;
    end
  end

  // Sticky error flags; a new event wins over clear_flags
  always_ff @(posedge sysClk) begin
    if (sysRst) begin
      overflow_flag    <= 1'b0;
      multi_valid_flag <= 1'b0;
      timeout_flag     <= 1'b0;
      timeout_target   <= 2'd0;
    end else begin
      if (overflow_evt)     overflow_flag <= 1'b1;
      else if (clear_flags) overflow_flag <= 1'b0;
      else                  overflow_flag <= overflow_flag;

      if (multi_valid)      multi_valid_flag <= 1'b1;
      else if (clear_flags) multi_valid_flag <= 1'b0;
      else                  multi_valid_flag <= multi_valid_flag;

      if (timeout_evt) begin
        timeout_flag   <= 1'b1;
        timeout_target <= active_tgt;
      end else if (clear_flags) begin
        timeout_flag   <= 1'b0;
        timeout_target <= 2'd0;
      end else begin
        timeout_flag   <= timeout_flag;
        timeout_target <= timeout_target;
      end
    end
  end

endmodule

// File: tb/tb_mcb_command_dispatcher.sv
// Directed bench for mcb_command_dispatcher. Expected issues are pushed to a
// scoreboard queue as commands are driven and compared when a req rises.
module tb_mcb_command_dispatcher;

  logic        sysClk = 1'b0;
  logic        sysRst = 1'b1;
  logic [7:0]  instruction = 8'h00;
  logic [63:0] data = 64'h0;
  logic        valid_buffer_for_camwrite = 1'b0;
  logic        valid_buffer_for_read = 1'b0;
  logic        valid_buffer_for_mem = 1'b0;
  logic        camwrite_done = 1'b0;
  logic        read_done = 1'b0;
  logic        mem_done = 1'b0;
  logic        clear_flags = 1'b0;
  logic        camwrite_req, read_req, mem_req;
  logic [7:0]  cmd_instruction;
  logic [63:0] cmd_data;
  logic        busy, queue_full, overflow_flag, multi_valid_flag, timeout_flag;
  logic [1:0]  timeout_target;

  int          checks = 0;
  int          failures = 0;
  logic [73:0] expq[$];
  logic [2:0]  prev_req = 3'b000;

  mcb_command_dispatcher #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_W      (24),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .sysClk                    (sysClk),
    .sysRst                    (sysRst),
    .instruction               (instruction),
    .data                      (data),
    .valid_buffer_for_camwrite (valid_buffer_for_camwrite),
    .valid_buffer_for_read     (valid_buffer_for_read),
    .valid_buffer_for_mem      (valid_buffer_for_mem),
    .camwrite_done             (camwrite_done),
    .read_done                 (read_done),
    .mem_done                  (mem_done),
    .clear_flags               (clear_flags),
    .camwrite_req              (camwrite_req),
    .read_req                  (read_req),
    .mem_req                   (mem_req),
    .cmd_instruction           (cmd_instruction),
    .cmd_data                  (cmd_data),
    .busy                      (busy),
    .queue_full                (queue_full),
    .overflow_flag             (overflow_flag),
    .multi_valid_flag          (multi_valid_flag),
    .timeout_flag              (timeout_flag),
    .timeout_target            (timeout_target)
  );

  // free-running system clock
  always #5 sysClk = ~sysClk;

  function automatic logic [2:0] tgt2req(input logic [1:0] t);
    case (t)
      2'd1:    return 3'b100;
      2'd2:    return 3'b010;
      2'd3:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock; at the falling edge check req exclusivity and score new issues
  task automatic tick();
    logic [2:0]  cur;
    logic [73:0] e;
    @(posedge sysClk);
    @(negedge sysClk);
    cur = {camwrite_req, read_req, mem_req};
    chk("req_at_most_one", 64'($countones(cur) <= 1), 64'd1);
    if (cur != 3'b000 && prev_req == 3'b000) begin
      if (expq.size() == 0) begin
        chk("issue_unexpected", 64'(cur), 64'd0);
      end else begin
        e = expq.pop_front();
        chk("issue_req", 64'(cur), 64'(tgt2req(e[73:72])));
        chk("issue_instr", 64'(cmd_instruction), 64'(e[71:64]));
        chk("issue_data", cmd_data, e[63:0]);
      end
    end
    prev_req = cur;
  endtask

  task automatic send(input logic [1:0] tgt, input logic [7:0] ins, input logic [63:0] d,
                      input bit acc);
    instruction = ins;
    data        = d;
    {valid_buffer_for_camwrite, valid_buffer_for_read, valid_buffer_for_mem} = tgt2req(tgt);
    if (acc) expq.push_back({tgt, ins, d});
    tick();
    {valid_buffer_for_camwrite, valid_buffer_for_read, valid_buffer_for_mem} = 3'b000;
  endtask

  initial begin
    int hi;

    // reset state
    tick();
    tick();
    chk("rst_reqs", 64'({camwrite_req, read_req, mem_req}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_full", 64'(queue_full), 64'd0);
    chk("rst_flags", 64'({overflow_flag, multi_valid_flag, timeout_flag, timeout_target}), 64'd0);
    chk("rst_cmd", 64'(cmd_instruction) | cmd_data, 64'd0);
    sysRst = 1'b0;
    tick();

    // single mem command: req at N+2, done at M -> req low M+1, idle M+2
    send(2'd3, 8'h21, 64'h0123_4567_89AB_CDEF, 1'b1);
    chk("t1_req_n1", 64'(mem_req), 64'd0);
    chk("t1_busy_n1", 64'(busy), 64'd1);
    tick();
    chk("t1_req_n2", 64'(mem_req), 64'd1);
    chk("t1_instr", 64'(cmd_instruction), 64'h21);
    chk("t1_data", cmd_data, 64'h0123_4567_89AB_CDEF);
    tick();
    tick();
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("t1_req_m1", 64'(mem_req), 64'd0);
    chk("t1_busy_m1", 64'(busy), 64'd1);
    tick();
    chk("t1_busy_m2", 64'(busy), 64'd0);

    // two valids together: dropped, multi_valid_flag set then cleared
    instruction = 8'h33;
    data = 64'h3333;
    valid_buffer_for_read = 1'b1;
    valid_buffer_for_mem  = 1'b1;
    tick();
    valid_buffer_for_read = 1'b0;
    valid_buffer_for_mem  = 1'b0;
    chk("t3_flag", 64'(multi_valid_flag), 64'd1);
    chk("t3_busy", 64'(busy), 64'd0);
    tick();
    chk("t3_noreq", 64'({camwrite_req, read_req, mem_req}), 64'd0);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    chk("t3_cleared", 64'(multi_valid_flag), 64'd0);

    // done on the final timeout cycle wins; foreign done ignored
    send(2'd3, 8'h44, 64'h4444_0000_0000_0044, 1'b1);
    tick();                          // first ISSUE cycle, counter 0
    chk("t5_req", 64'(mem_req), 64'd1);
    tick(); tick(); tick();          // counter 3
    camwrite_done = 1'b1;
    tick();
    camwrite_done = 1'b0;
    chk("t5_foreign_done", 64'(mem_req), 64'd1);
    for (int i = 0; i < 11; i++) tick();   // counter 15, last cycle before abort
    chk("t5_req_last", 64'(mem_req), 64'd1);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("t5_req_drop", 64'(mem_req), 64'd0);
    chk("t5_no_timeout", 64'(timeout_flag), 64'd0);
    tick();
    chk("t5_idle", 64'(busy), 64'd0);

    // read command times out after 16 ISSUE cycles; queued mem follows
    send(2'd2, 8'h55, 64'h5555, 1'b1);
    send(2'd3, 8'h66, 64'h6666, 1'b1);
    hi = 0;
    if (read_req) hi = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (read_req) hi++;
      else break;
    end
    chk("t4_req_cycles", 64'(hi), 64'd16);
    chk("t4_flag", 64'(timeout_flag), 64'd1);
    chk("t4_target", 64'(timeout_target), 64'd2);
    chk("t4_recover_gap", 64'(mem_req), 64'd0);
    tick();
    chk("t4_next_issue", 64'(mem_req), 64'd1);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    tick();
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    chk("t4_cleared", 64'({timeout_flag, timeout_target}), 64'd0);

    // mem command in flight, then five camwrites: four fill the queue, fifth overflows
    send(2'd3, 8'h70, 64'h7070, 1'b1);
    send(2'd1, 8'h81, 64'h8181, 1'b1);
    send(2'd1, 8'h82, 64'h8282, 1'b1);
    send(2'd1, 8'h83, 64'h8383, 1'b1);
    chk("t2_not_full", 64'(queue_full), 64'd0);
    send(2'd1, 8'h84, 64'h8484, 1'b1);
    chk("t2_full", 64'(queue_full), 64'd1);
    chk("t2_no_ovf_yet", 64'(overflow_flag), 64'd0);
    send(2'd1, 8'h85, 64'h8585, 1'b0);
    chk("t2_ovf", 64'(overflow_flag), 64'd1);
    chk("t2_still_full", 64'(queue_full), 64'd1);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!busy) break;
    end
    chk("t2_drained", 64'(busy), 64'd0);
    chk("t2_all_issued", 64'(expq.size()), 64'd0);
    chk("t2_tmo_target", 64'(timeout_target), 64'd1);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;

    // reset mid-ISSUE with three queued: everything drops, nothing issues after
    send(2'd2, 8'h91, 64'h9191, 1'b1);
    send(2'd3, 8'h92, 64'h9292, 1'b1);
    send(2'd1, 8'h93, 64'h9393, 1'b1);
    send(2'd2, 8'h94, 64'h9494, 1'b1);
    chk("t6_in_issue", 64'(read_req), 64'd1);
    sysRst = 1'b1;
    expq.delete();
    tick();
    sysRst = 1'b0;
    chk("t6_reqs", 64'({camwrite_req, read_req, mem_req}), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_full", 64'(queue_full), 64'd0);
    for (int i = 0; i < 20; i++) tick();
    chk("t6_quiet", 64'({camwrite_req, read_req, mem_req, busy}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
